// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver, 16x oversampling with 6-sample majority vote
module uart_rx_param #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop_bits,
    input  logic              Rs232_Rx,
    output logic [DATA_W-1:0] data_byte,
    output logic              Rx_Done,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 4);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_next;

    logic              rx_s1, rx_s2, rx_prev;
    logic [DIV_W-1:0]  div_l, div_cnt;
    logic [1:0]        par_l;
    logic              stop2_l;
    logic [3:0]        sub_cnt;
    logic [2:0]        vote_sum, sum_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_acc, perr_acc, ferr_acc;
    logic              fall, tick, in_window, bit_val, vote_pt, bit_end;
    logic              par_en, last_stop, done;

    assign fall      = rx_prev & ~rx_s2;
    assign tick      = (state != IDLE) && (div_cnt == div_l);
    assign in_window = (sub_cnt >= 4'd6) && (sub_cnt <= 4'd11);
    assign sum_next  = vote_sum + {2'b00, in_window & rx_s2};
    assign bit_val   = (sum_next >= 3'd4);
    assign vote_pt   = tick && (sub_cnt == 4'd11);
    assign bit_end   = tick && (sub_cnt == 4'd15);
    assign par_en    = (par_l == 2'b01) || (par_l == 2'b10);
    assign last_stop = (bit_cnt == {{(CNT_W-1){1'b0}}, stop2_l});
    // Completion happens at the vote of the final stop bit so a new start edge can follow immediately
    assign done      = (state == STOP) && vote_pt && last_stop;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = START;
            START: begin
                if (vote_pt && bit_val) state_next = IDLE;
                else if (bit_end)       state_next = DATA;
            end
            DATA:    if (bit_end && bit_cnt == LAST_DATA) state_next = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            div_l      <= '0;
            par_l      <= '0;
            stop2_l    <= 1'b0;
            div_cnt    <= '0;
            sub_cnt    <= '0;
            vote_sum   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_acc    <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            data_byte  <= '0;
            Rx_Done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1   <= Rs232_Rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            Rx_Done <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                sub_cnt  <= '0;
                vote_sum <= '0;
                bit_cnt  <= '0;
                par_acc  <= 1'b0;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
                if (fall) begin
                    div_l   <= baud_div;
                    par_l   <= parity_mode;
                    stop2_l <= stop_bits;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    sub_cnt  <= sub_cnt + 4'd1;
                    vote_sum <= (sub_cnt == 4'd15) ? 3'd0 : sum_next;
                end
                if (vote_pt) begin
                    case (state)
                        DATA: begin
                            shift   <= {bit_val, shift[DATA_W-1:1]};
                            par_acc <= par_acc ^ bit_val;
                        end
                        // Even parity expects an overall XOR of 0, odd parity expects 1
                        PARITY: perr_acc <= (par_acc ^ bit_val) != (par_l == 2'b10);
                        STOP: begin
                            if (!bit_val) ferr_acc <= 1'b1;
                            if (last_stop) begin
                                Rx_Done    <= 1'b1;
                                data_byte  <= shift;
                                parity_err <= perr_acc;
                                frame_err  <= ferr_acc | ~bit_val;
                            end
                        end
                        default: ;
                    endcase
                end
                if (bit_end) begin
                    if ((state == DATA && bit_cnt != LAST_DATA) || state == STOP)
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    else
                        bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param with frame table and scoreboard
module tb_uart_rx_param;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        Rs232_Rx;
    logic [7:0]  data_byte;
    logic        Rx_Done;
    logic        parity_err;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    uart_rx_param #(.DATA_W(8), .DIV_W(16)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .stop_bits  (stop_bits),
        .Rs232_Rx   (Rs232_Rx),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       s2;
        logic       flip;
        logic       stop_low;
        int         dv;
        logic       ep;
        logic       ef;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[8];
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (Rx_Done) begin
            check("done_width", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=%0h expected=none", data_byte);
            end else begin
                e = sb.pop_front();
                check("data_byte", {24'b0, data_byte}, {24'b0, e.data});
                check("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
                check("frame_err", {31'b0, frame_err}, {31'b0, e.ferr});
            end
        end
        prev_done = Rx_Done;
    end

    task automatic send_bit(input logic v, input int dv, input bit noisy);
        if (!noisy) begin
            Rs232_Rx = v;
            wait_clks(16 * (dv + 1));
        end else begin
            Rs232_Rx = v;
            wait_clks(9 * (dv + 1));
            Rs232_Rx = ~v;
            wait_clks(2 * (dv + 1));
            Rs232_Rx = v;
            wait_clks(5 * (dv + 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                              input logic flip, input logic stop_low, input int dv,
                              input int idle_bits, input bit noisy, input logic ep, input logic ef);
        exp_t t;
        logic p;
        baud_div    = dv[15:0];
        parity_mode = pm;
        stop_bits   = s2;
        t.data = d;
        t.perr = ep;
        t.ferr = ef;
        sb.push_back(t);
        send_bit(1'b0, dv, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], dv, noisy);
        if (pm == 2'b01 || pm == 2'b10) begin
            p = (pm == 2'b01) ? ^d : ~^d;
            send_bit(p ^ flip, dv, 1'b0);
        end
        repeat (s2 ? 2 : 1) send_bit(~stop_low, dv, 1'b0);
        Rs232_Rx = 1'b1;
        wait_clks(idle_bits * 16 * (dv + 1));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 26, 1'b0, 1'b0};
        tbl[1] = '{8'h37, 2'b01, 1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0};
        tbl[2] = '{8'h37, 2'b01, 1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b0};
        tbl[3] = '{8'h37, 2'b10, 1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0};
        tbl[4] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 3,  1'b0, 1'b1};
        tbl[5] = '{8'hC3, 2'b00, 1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0};
        tbl[6] = '{8'h5A, 2'b11, 1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b0};
        tbl[7] = '{8'h0F, 2'b10, 1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b0};

        Rst = 1'b1;
        baud_div = 16'd3;
        parity_mode = 2'b00;
        stop_bits = 1'b0;
        Rs232_Rx = 1'b1;
        wait_clks(4);
        check("rst_data_byte", {24'b0, data_byte}, 32'd0);
        check("rst_rx_done", {31'b0, Rx_Done}, 32'd0);
        check("rst_parity_err", {31'b0, parity_err}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        Rst = 1'b0;
        wait_clks(10);

        for (int i = 0; i < 8; i++)
            send_frame(tbl[i].data, tbl[i].pm, tbl[i].s2, tbl[i].flip, tbl[i].stop_low,
                       tbl[i].dv, 2, 1'b0, tbl[i].ep, tbl[i].ef);

        // false start: low for 3 ticks only
        Rs232_Rx = 1'b0;
        wait_clks(3 * 4);
        Rs232_Rx = 1'b1;
        wait_clks(3 * 64);
        check("false_start_no_done", sb.size(), 32'd0);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);

        // back-to-back two-stop-bit frames, no idle gap
        send_frame(8'h01, 2'b00, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFE, 2'b00, 1'b1, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);

        // baud_div changed mid-frame
        fork
            send_frame(8'h69, 2'b00, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);
            begin
                wait_clks(150);
                baud_div = 16'd7;
            end
        join

        // break: line held low well past a full frame
        baud_div = 16'd3;
        parity_mode = 2'b00;
        stop_bits = 1'b0;
        begin
            exp_t t;
            t.data = 8'h00;
            t.perr = 1'b0;
            t.ferr = 1'b1;
            sb.push_back(t);
        end
        Rs232_Rx = 1'b0;
        wait_clks(14 * 64);
        check("break_done_once", sb.size(), 32'd0);
        Rs232_Rx = 1'b1;
        wait_clks(3 * 64);

        // noisy data bits
        send_frame(8'h96, 2'b00, 1'b0, 1'b0, 1'b0, 3, 2, 1'b1, 1'b0, 1'b0);

        // reset mid-DATA
        baud_div = 16'd3;
        send_bit(1'b0, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        send_bit(1'b0, 3, 1'b0);
        Rs232_Rx = 1'b1;
        wait_clks(30);
        Rst = 1'b1;
        #1;
        check("midrst_data_byte", {24'b0, data_byte}, 32'd0);
        check("midrst_rx_done", {31'b0, Rx_Done}, 32'd0);
        check("midrst_parity_err", {31'b0, parity_err}, 32'd0);
        check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
        wait_clks(3);
        Rst = 1'b0;
        wait_clks(12 * 64);
        send_frame(8'hB4, 2'b01, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2000 && sb.size() != 0; i++) wait_clks(1);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
